// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pattern generator and related board examples.
// Holds RGB888 colour constants, the pattern-mode encoding, the default
// 480x272 panel geometry, and small helpers used by the pattern logic.
package lcd_pkg;

  // Default panel geometry
  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int BOX_SIZE_DEF = 32;

  typedef logic [23:0] rgb_t;

  // RGB888 colours: [23:16]=R, [15:8]=G, [7:0]=B
  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t MAGENTA = 24'hFF00FF;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t BLACK   = 24'h000000;
  localparam rgb_t NAVY    = 24'h000080;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_BOX  = 2'd2,
    MODE_GRAD = 2'd3
  } mode_e;

  // Position and direction along one axis of the bouncing box.
  typedef struct packed {
    logic [11:0] pos;
    logic        fwd;   // 1 = moving towards larger coordinates
  } axis_t;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

  // One frame step of a bouncing axis. Hitting a limit reverses the
  // direction and moves one step the other way on the same frame, so the
  // box never rests on an edge for two frames.
  function automatic axis_t axis_step(input axis_t cur, input logic [11:0] max_pos);
    axis_t nxt;
    nxt = cur;
    if (cur.fwd) begin
      if (cur.pos == max_pos) begin
        nxt.fwd = 1'b0;
        nxt.pos = cur.pos - 12'd1;
      end else begin
        nxt.pos = cur.pos + 12'd1;
      end
    end else begin
      if (cur.pos == 12'd0) begin
        nxt.fwd = 1'b1;
        nxt.pos = 12'd1;
      end else begin
        nxt.pos = cur.pos - 12'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-time debounce counter
// and a one-cycle pulse on each debounced rising edge.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   btn  - raw button level, asynchronous to clk
//   rise - one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1, sync_q2, sync_prev;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      rise      <= 1'b0;
    end else begin
      sync_q1   <= btn;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
      rise      <= 1'b0;
      if (sync_q2 != sync_prev) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Input has held for the full window: adopt it as the stable level.
        stable <= sync_q2;
        rise   <= sync_q2 & ~stable;
      end
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for a 480x272 RGB panel driven by lcd_ctrl.
// Produces a registered RGB888 pixel from the coordinates lcd_ctrl presents,
// with four patterns (bars, grid, bouncing box, gradient) selected by a
// debounced button. Pattern changes commit on frame ticks only.
// Ports:
//   clk, rst   - pixel clock; synchronous active-high reset
//   lcd_xpos   - horizontal coordinate from lcd_ctrl
//   lcd_ypos   - vertical coordinate from lcd_ctrl
//   lcd_vs     - vsync from lcd_ctrl (frame-start detection)
//   mode_btn   - raw push-button, active-high, asynchronous
//   lcd_data   - registered RGB888 pixel, one cycle after the coordinates
//   mode       - pattern currently displayed
//   frame_tick - one-cycle pulse per detected frame start
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int BOX_SIZE      = BOX_SIZE_DEF,
  parameter int DEB_CYCLES    = 200000,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lcd_xpos,
  input  logic [11:0] lcd_ypos,
  input  logic        lcd_vs,
  input  logic        mode_btn,
  output logic [23:0] lcd_data,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  localparam int          BAR_W   = H_ACTIVE / 8;
  localparam logic [11:0] BX_MAX  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] BY_MAX  = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic        VS_IDLE = (VS_ACTIVE_LOW != 0);

  mode_e       mode_q, pending_mode;
  logic        vs_q1, vs_q2, vs_q3;
  logic        btn_rise;
  logic [7:0]  frame_cnt;
  logic [11:0] bx, by;
  logic        dx, dy;
  axis_t       x_next, y_next;
  rgb_t        pixel;
  logic [2:0]  bar_idx;
  logic        in_box;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (mode_btn),
    .rise (btn_rise)
  );

  // Edge detect on the registered copy (vs_q2 vs. its delayed copy vs_q3):
  // the tick is decoded from flops only and lands 2 cycles after the input edge.
  assign frame_tick = (VS_ACTIVE_LOW != 0) ? (vs_q3 & ~vs_q2) : (~vs_q3 & vs_q2);
  assign mode       = mode_q;

  assign x_next = axis_step('{pos: bx, fwd: dx}, BX_MAX);
  assign y_next = axis_step('{pos: by, fwd: dy}, BY_MAX);

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pixel   = BLACK;
    bar_idx = 3'd7;
    // Lowest bar whose right boundary lies beyond xpos; constant compares only.
    for (int i = 7; i >= 0; i--) begin
      if (lcd_xpos < 12'(BAR_W * (i + 1))) bar_idx = 3'(i);
    end
    in_box = ({1'b0, lcd_xpos} >= {1'b0, bx}) &&
             ({1'b0, lcd_xpos} <  {1'b0, bx} + 13'(BOX_SIZE)) &&
             ({1'b0, lcd_ypos} >= {1'b0, by}) &&
             ({1'b0, lcd_ypos} <  {1'b0, by} + 13'(BOX_SIZE));
    if (lcd_xpos < 12'(H_ACTIVE) && lcd_ypos < 12'(V_ACTIVE)) begin
      case (mode_q)
        MODE_BARS: pixel = bar_colour(bar_idx);
        MODE_GRID: pixel = (lcd_xpos[4:0] == 5'd0 || lcd_ypos[4:0] == 5'd0) ? WHITE : BLACK;
        MODE_BOX:  pixel = in_box ? RED : NAVY;
        MODE_GRAD: pixel = {lcd_xpos[8:1], lcd_ypos[7:0], frame_cnt};
        default:   pixel = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data     <= BLACK;
      mode_q       <= MODE_BARS;
      pending_mode <= MODE_BARS;
      vs_q1        <= VS_IDLE;
      vs_q2        <= VS_IDLE;
      vs_q3        <= VS_IDLE;
      frame_cnt    <= 8'd0;
      bx           <= 12'd0;
      by           <= 12'd0;
      dx           <= 1'b1;
      dy           <= 1'b1;
    end else begin
      lcd_data <= pixel;
      vs_q1    <= lcd_vs;
      vs_q2    <= vs_q1;
      vs_q3    <= vs_q2;
      // Derived from the displayed mode, so repeated presses within a frame
      // collapse to a single step.
      if (btn_rise) pending_mode <= mode_e'(2'(mode_q + 2'd1));
      if (frame_tick) begin
        mode_q    <= pending_mode;
        frame_cnt <= frame_cnt + 8'd1;
        bx        <= x_next.pos;
        dx        <= x_next.fwd;
        by        <= y_next.pos;
        dy        <= y_next.fwd;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed self-checking bench for lcd_pattern_gen (short debounce window).
module tb_lcd_pattern_gen;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lcd_xpos = 12'd100;
  logic [11:0] lcd_ypos = 12'd10;
  logic        lcd_vs = 1'b1;
  logic        mode_btn = 1'b0;
  logic [23:0] lcd_data;
  logic [1:0]  mode;
  logic        frame_tick;

  int n_checks = 0;
  int n_bad    = 0;
  int nframes  = 0;
  int ticks    = 0;

  lcd_pattern_gen #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_xpos   (lcd_xpos),
    .lcd_ypos   (lcd_ypos),
    .lcd_vs     (lcd_vs),
    .mode_btn   (mode_btn),
    .lcd_data   (lcd_data),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    lcd_vs = 1'b0;
    repeat (3) begin step(); if (frame_tick) ticks++; end
    lcd_vs = 1'b1;
    repeat (3) begin step(); if (frame_tick) ticks++; end
    nframes++;
  endtask

  task automatic press(input int hold);
    mode_btn = 1'b1;
    repeat (hold) step();
    mode_btn = 1'b0;
    repeat (DEB + 10) step();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    lcd_xpos = 12'(x);
    lcd_ypos = 12'(y);
    step();
    check(tag, lcd_data, exp);
  endtask

  int          bar_x [7] = '{0, 59, 60, 419, 420, 479, 480};
  logic [23:0] bar_c [7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF,
                             24'h000000, 24'h000000, 24'h000000};

  initial begin
    // Reset with non-trivial inputs present
    repeat (3) step();
    check("rst_data", lcd_data, 24'h0);
    check("rst_mode", 24'(mode), 24'd0);
    check("rst_tick", 24'(frame_tick), 24'd0);
    rst = 1'b0;
    step();

    // Frame-tick latency: high exactly once, 2 cycles after the vsync edge
    lcd_vs = 1'b0;
    step(); check("tick_c1", 24'(frame_tick), 24'd0);
    step(); check("tick_c2", 24'(frame_tick), 24'd1);
    step(); check("tick_c3", 24'(frame_tick), 24'd0);
    lcd_vs = 1'b1;
    repeat (3) step();
    nframes++;
    ticks++;
    check("first_bx", 24'(dut.bx), 24'd1);
    check("first_by", 24'(dut.by), 24'd1);

    // Colour bars
    foreach (bar_x[i]) pix($sformatf("bar_x%0d", bar_x[i]), bar_x[i], 10, bar_c[i]);
    pix("bar_y272", 10, 272, 24'h0);

    // Short glitch is rejected
    press(DEB / 2);
    frame();
    check("glitch_mode", 24'(mode), 24'd0);

    // Real press waits for the frame tick
    press(DEB + 10);
    check("press_before_tick", 24'(mode), 24'd0);
    frame();
    check("press_after_tick", 24'(mode), 24'd1);

    // Grid
    pix("grid_0_5",   0,   5, 24'hFFFFFF);
    pix("grid_32_7",  32,  7, 24'hFFFFFF);
    pix("grid_5_64",  5,  64, 24'hFFFFFF);
    pix("grid_5_5",   5,   5, 24'h000000);
    pix("grid_33_33", 33, 33, 24'h000000);
    pix("grid_480_0", 480, 0, 24'h000000);

    // Two presses in one frame advance only one step
    press(DEB + 10);
    press(DEB + 10);
    frame();
    check("double_press", 24'(mode), 24'd2);

    // Box at bx=by=4 after four frames
    pix("box_4_4",    4,   4, 24'hFF0000);
    pix("box_35_35",  35, 35, 24'hFF0000);
    pix("box_36_35",  36, 35, 24'h000080);
    pix("box_35_36",  35, 36, 24'h000080);
    pix("box_3_10",   3,  10, 24'h000080);
    pix("box_10_300", 10, 300, 24'h000000);

    // Bounce
    while (nframes < 449) begin
      frame();
      if (nframes == 240) check("by_240", 24'(dut.by), 24'd240);
      if (nframes == 241) begin
        check("by_241", 24'(dut.by), 24'd239);
        check("dy_241", 24'(dut.dy), 24'd0);
      end
      if (nframes == 448) begin
        check("bx_448", 24'(dut.bx), 24'd448);
        check("dx_448", 24'(dut.dx), 24'd1);
      end
      if (nframes == 449) begin
        check("bx_449", 24'(dut.bx), 24'd447);
        check("dx_449", 24'(dut.dx), 24'd0);
      end
    end
    // bx=447, by=31
    pix("bnc_447_31", 447, 31, 24'hFF0000);
    pix("bnc_446_31", 446, 31, 24'h000080);
    pix("bnc_478_62", 478, 62, 24'hFF0000);
    pix("bnc_479_62", 479, 62, 24'h000080);
    check("tick_count", 24'(ticks), 24'(nframes));

    // Gradient
    press(DEB + 10);
    frame();
    check("grad_mode", 24'(mode), 24'd3);
    pix("grad_100_50", 100, 50, {8'd50, 8'd50, 8'(nframes % 256)});
    pix("grad_479_271", 479, 271, {8'hEF, 8'h0F, 8'(nframes % 256)});

    // Mid-frame reset with frame_cnt at 5
    while ((nframes % 256) != 5) frame();
    check("fc_5", 24'(dut.frame_cnt), 24'd5);
    lcd_xpos = 12'd100;
    lcd_ypos = 12'd50;
    rst = 1'b1;
    step();
    check("mrst_data", lcd_data, 24'h0);
    check("mrst_mode", 24'(mode), 24'd0);
    check("mrst_fc", 24'(dut.frame_cnt), 24'd0);
    check("mrst_bx", 24'(dut.bx), 24'd0);
    rst = 1'b0;
    pix("resume_bar", 60, 10, 24'hFFFF00);
    pix("resume_bar0", 5, 10, 24'hFFFFFF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
